systolic_array_nxn: RTL and testbench

- Output-stationary N×N systolic matrix-multiply array: computes C = A·B for square N×N matrices of unsigned DW-bit elements.
- A rows enter from the left edge and shift right; B columns enter from the top edge and shift down. Each processing element (PE) keeps its own PW-bit accumulator.
- Used as the compute core. An upstream feeder supplies the skewed operand streams; a downstream reader samples C directly.

---
 rtl/systolic_array_nxn.sv | 66 ++++++
 tb/tb_systolic_array_nxn.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_nxn.sv
// systolic_array_nxn: output-stationary NxN unsigned matrix-multiply array.
// A streams right along rows, B streams down columns, each PE accumulates.
module systolic_array_nxn #(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int PW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] A_in [N],
  input  logic [DW-1:0] B_in [N],
  output logic [PW-1:0] C    [N][N]
);

  logic [DW-1:0] a_q [N][N];
  logic [DW-1:0] b_q [N][N];
  logic [PW-1:0] acc [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0]   a_op;
      logic [DW-1:0]   b_op;
      logic [2*DW-1:0] prod;

      if (j == 0) begin : g_a_edge
        assign a_op = A_in[i];
      end else begin : g_a_int
        assign a_op = a_q[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_op = B_in[j];
      end else begin : g_b_int
        assign b_op = b_q[i-1][j];
      end

      assign prod = (2*DW)'(a_op) * (2*DW)'(b_op);

      // shift operands onward and accumulate their product (wraps mod 2^PW)
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
          acc[i][j] <= '0;
        end else begin
          a_q[i][j] <= a_op;
          b_q[i][j] <= b_op;
          acc[i][j] <= acc[i][j] + PW'(prod);
        end
      end

      assign C[i][j] = acc[i][j];

      // operands leaving the far edges have no consumer
      if (j == N-1) begin : g_a_sink
        logic unused_a;
        assign unused_a = ^a_q[i][j];
      end
      if (i == N-1) begin : g_b_sink
        logic unused_b;
        assign unused_b = ^b_q[i][j];
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// tb_systolic_array_nxn: table-driven bench with scoreboard for the
// 3x3 array, run at PW=32 and PW=16 side by side.
module tb_systolic_array_nxn;

  localparam int N  = 3;
  localparam int DW = 8;

  typedef logic [N-1:0][N-1:0][DW-1:0] m8_t;
  typedef logic [N-1:0][N-1:0][31:0]   m32_t;

  typedef struct packed {
    m8_t  a;
    m8_t  b;
    logic rst_first;
    m32_t exp;
  } vec_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] a_in [N];
  logic [DW-1:0] b_in [N];
  logic [31:0]   c32  [N][N];
  logic [15:0]   c16  [N][N];

  int   checks;
  int   errors;
  m32_t sb [$];

  systolic_array_nxn #(.N(N), .DW(DW), .PW(32)) u_dut32 (
    .clk  (clk),
    .rst  (rst),
    .A_in (a_in),
    .B_in (b_in),
    .C    (c32)
  );

  systolic_array_nxn #(.N(N), .DW(DW), .PW(16)) u_dut16 (
    .clk  (clk),
    .rst  (rst),
    .A_in (a_in),
    .B_in (b_in),
    .C    (c16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic m8_t mk8(
    input int v0, input int v1, input int v2,
    input int v3, input int v4, input int v5,
    input int v6, input int v7, input int v8
  );
    m8_t m;
    m[0][0] = 8'(v0); m[0][1] = 8'(v1); m[0][2] = 8'(v2);
    m[1][0] = 8'(v3); m[1][1] = 8'(v4); m[1][2] = 8'(v5);
    m[2][0] = 8'(v6); m[2][1] = 8'(v7); m[2][2] = 8'(v8);
    return m;
  endfunction

  function automatic m32_t mk32(
    input int v0, input int v1, input int v2,
    input int v3, input int v4, input int v5,
    input int v6, input int v7, input int v8
  );
    m32_t m;
    m[0][0] = 32'(v0); m[0][1] = 32'(v1); m[0][2] = 32'(v2);
    m[1][0] = 32'(v3); m[1][1] = 32'(v4); m[1][2] = 32'(v5);
    m[2][0] = 32'(v6); m[2][1] = 32'(v7); m[2][2] = 32'(v8);
    return m;
  endfunction

  function automatic m32_t matmul(input m8_t a, input m8_t b);
    m32_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        r[i][j] = '0;
        for (int k = 0; k < N; k++)
          r[i][j] = r[i][j] + 32'(a[i][k]) * 32'(b[k][j]);
      end
    return r;
  endfunction

  task automatic set_zero();
    for (int i = 0; i < N; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
    end
  endtask

  task automatic idle(input int n);
    set_zero();
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // skewed feed: A[i][k] at edge i+k, B[k][j] at edge j+k
  task automatic feed(input m8_t a, input m8_t b, input int n);
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < N; i++) begin
        a_in[i] = (t - i >= 0 && t - i < N) ? a[i][t-i] : '0;
        b_in[i] = (t - i >= 0 && t - i < N) ? b[t-i][i] : '0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    set_zero();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  task automatic check(input string name, input m32_t e);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (c32[i][j] !== e[i][j]) begin
          errors++;
          $display("FAIL %s c32[%0d][%0d] got %0d expected %0d",
                   name, i, j, c32[i][j], e[i][j]);
        end
        checks++;
        if (c16[i][j] !== e[i][j][15:0]) begin
          errors++;
          $display("FAIL %s c16[%0d][%0d] got %0d expected %0d",
                   name, i, j, c16[i][j], e[i][j][15:0]);
        end
      end
  endtask

  task automatic pop_check(input string name);
    m32_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty got 0 entries expected 1", name);
    end else begin
      e = sb.pop_front();
      check(name, e);
    end
  endtask

  vec_t vecs [6];
  m8_t  mm;
  m8_t  id;
  m8_t  ff;
  m8_t  rnd;
  m32_t basic;
  m32_t zero;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    set_zero();

    mm    = mk8(1, 2, 3, 4, 5, 6, 7, 8, 9);
    id    = mk8(1, 0, 0, 0, 1, 0, 0, 0, 1);
    ff    = mk8(255, 255, 255, 255, 255, 255, 255, 255, 255);
    basic = mk32(30, 36, 42, 66, 81, 96, 102, 126, 150);
    zero  = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        rnd[i][j] = 8'($urandom_range(0, 255));

    vecs[0] = '{a: mm, b: mm, rst_first: 1'b1, exp: basic};
    vecs[1] = '{a: mm, b: mm, rst_first: 1'b0,
                exp: mk32(60, 72, 84, 132, 162, 192, 204, 252, 300)};
    vecs[2] = '{a: id, b: mm, rst_first: 1'b1, exp: mk32(1, 2, 3, 4, 5, 6, 7, 8, 9)};
    vecs[3] = '{a: mm, b: id, rst_first: 1'b1, exp: mk32(1, 2, 3, 4, 5, 6, 7, 8, 9)};
    vecs[4] = '{a: ff, b: ff, rst_first: 1'b1,
                exp: mk32(195075, 195075, 195075, 195075, 195075,
                          195075, 195075, 195075, 195075)};
    vecs[5] = '{a: rnd, b: rnd, rst_first: 1'b1, exp: matmul(rnd, rnd)};

    // reset held with live operands while the clock runs
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      a_in[i] = 8'hA5;
      b_in[i] = 8'h5A;
    end
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("reset_hold", zero);
    set_zero();
    rst = 1'b1;

    // table-driven products
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].rst_first) do_reset();
      sb.push_back(vecs[v].exp);
      feed(vecs[v].a, vecs[v].b, 2*N-1);
      idle(N+1);
      pop_check($sformatf("vec%0d", v));
    end

    // result holds once the pipeline has drained
    sb.push_back(matmul(rnd, rnd));
    idle(6);
    pop_check("stable");

    // asynchronous reset between edges
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset", zero);
    @(negedge clk);
    rst = 1'b1;

    // back-to-back accumulation without reset
    do_reset();
    sb.push_back(mk32(60, 72, 84, 132, 162, 192, 204, 252, 300));
    feed(mm, mm, 2*N-1);
    feed(mm, mm, 2*N-1);
    idle(N+1);
    pop_check("back_to_back");

    // abort at edge 3, then a fresh run must leave no residue
    do_reset();
    feed(ff, ff, 4);
    rst = 1'b0;
    #1 check("mid_reset", zero);
    idle(1);
    rst = 1'b1;
    sb.push_back(basic);
    feed(mm, mm, 2*N-1);
    idle(N+1);
    pop_check("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
